// File: rtl/spart_driver.sv
// Bus sequencer for a SPART instance: programs the baud divisor, then arbitrates RX reads and TX writes.
// Optional received-byte echo is compiled in with `define SPART_ECHO_EN.
module spart_driver #(
   parameter int unsigned CLK_FREQ = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] br_cfg,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   input  logic       rda,
   input  logic       tbr,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data
);

   typedef enum logic [2:0] {
      StInit, StCfgLo, StCfgHi, StIdle, StRd, StWr, StEchoWr, StGuard
   } state_e;

   function automatic logic [15:0] calc_div(input logic [1:0] sel);
      int unsigned baud;
      baud = 32'd4800 << sel;
      return 16'(CLK_FREQ / (32'd16 * baud) - 32'd1);
   endfunction

   localparam logic [15:0] Div0 = calc_div(2'd0);
   localparam logic [15:0] Div1 = calc_div(2'd1);
   localparam logic [15:0] Div2 = calc_div(2'd2);
   localparam logic [15:0] Div3 = calc_div(2'd3);

   state_e      state_q;
   logic [1:0]  br_q;
   logic [7:0]  div_hi_q;
   logic [7:0]  dout_q;
   logic        iocs_q, iorw_q, tx_ready_q, rx_valid_q;
   logic [1:0]  ioaddr_q;
   logic [7:0]  rx_data_q;
   logic [15:0] div_new;
   logic        echo_pend;

   always_comb begin
      div_new = Div0;
      unique case (br_cfg)
         2'd0: div_new = Div0;
         2'd1: div_new = Div1;
         2'd2: div_new = Div2;
         2'd3: div_new = Div3;
         default: div_new = Div0;
      endcase
   end

`ifdef SPART_ECHO_EN
   logic echo_q;
   assign echo_pend = echo_q;
`else
   assign echo_pend = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StInit;
         br_q       <= 2'b00;
         div_hi_q   <= 8'h00;
         dout_q     <= 8'h00;
         iocs_q     <= 1'b0;
         iorw_q     <= 1'b1;
         ioaddr_q   <= 2'b00;
         tx_ready_q <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
`ifdef SPART_ECHO_EN
         echo_q     <= 1'b0;
`endif
      end else begin
         // Outputs describe the state being entered, so they are set alongside the transition.
         iocs_q     <= 1'b0;
         iorw_q     <= 1'b1;
         ioaddr_q   <= 2'b00;
         tx_ready_q <= 1'b0;
         rx_valid_q <= 1'b0;
         case (state_q)
            StInit: begin
               br_q     <= br_cfg;
               div_hi_q <= div_new[15:8];
               dout_q   <= div_new[7:0];
               iocs_q   <= 1'b1;
               iorw_q   <= 1'b0;
               ioaddr_q <= 2'b10;
               state_q  <= StCfgLo;
            end
            StCfgLo: begin
               dout_q   <= div_hi_q;
               iocs_q   <= 1'b1;
               iorw_q   <= 1'b0;
               ioaddr_q <= 2'b11;
               state_q  <= StCfgHi;
            end
            StCfgHi: state_q <= StIdle;
            StIdle: begin
               if (br_cfg != br_q) begin
                  br_q     <= br_cfg;
                  div_hi_q <= div_new[15:8];
                  dout_q   <= div_new[7:0];
                  iocs_q   <= 1'b1;
                  iorw_q   <= 1'b0;
                  ioaddr_q <= 2'b10;
                  state_q  <= StCfgLo;
               end else if (rda) begin
                  iocs_q  <= 1'b1;
                  state_q <= StRd;
               end else if (echo_pend && tbr) begin
                  dout_q  <= rx_data_q;
                  iocs_q  <= 1'b1;
                  iorw_q  <= 1'b0;
                  state_q <= StEchoWr;
               end else if (tx_valid && tbr && !echo_pend) begin
                  dout_q     <= tx_data;
                  iocs_q     <= 1'b1;
                  iorw_q     <= 1'b0;
                  tx_ready_q <= 1'b1;
                  state_q    <= StWr;
               end
            end
            StRd: begin
               rx_data_q  <= databus;
               rx_valid_q <= 1'b1;
`ifdef SPART_ECHO_EN
               echo_q     <= 1'b1;
`endif
               state_q    <= StGuard;
            end
            StWr: state_q <= StGuard;
            StEchoWr: begin
`ifdef SPART_ECHO_EN
               echo_q  <= 1'b0;
`endif
               state_q <= StGuard;
            end
            StGuard: state_q <= StIdle;
            default: state_q <= StInit;
         endcase
      end
   end

   assign databus  = (iocs_q && !iorw_q) ? dout_q : 8'bz;
   assign iocs     = iocs_q;
   assign iorw     = iorw_q;
   assign ioaddr   = ioaddr_q;
   assign tx_ready = tx_ready_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spart_driver.sv
// Scoreboard bench for spart_driver: stimulus queues expected bus/handshake events, a monitor checks them.
module tb_spart_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] br_cfg = 2'b01;
   logic       iocs, iorw, tx_ready, rx_valid;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic       rda = 1'b0, tbr = 1'b0, tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00, rx_data, rd_val = 8'h00;

   // kind: 0 bus write, 1 bus read, 2 rx_valid pulse, 3 tx_ready pulse
   typedef struct {int kind; int addr; int data; int cyc;} ev_t;
   ev_t exp_q[$];
   int  n_total = 0, n_pass = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign databus = (iocs && iorw) ? rd_val : 8'bz;

   spart_driver #(.CLK_FREQ(50000000)) dut (
      .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .databus(databus), .rda(rda), .tbr(tbr), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic push(input int kind, input int addr, input int data, input int c);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input int addr, input int data);
      ev_t e;
      n_total++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_event: kind %0d addr %0d data 0x%0h cyc %0d, expected none",
                  kind, addr, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind == kind && e.addr == addr && e.data == data && e.cyc == cyc) n_pass++;
         else $display("FAIL event: got kind %0d addr %0d data 0x%0h cyc %0d, expected kind %0d addr %0d data 0x%0h cyc %0d",
                       kind, addr, data, cyc, e.kind, e.addr, e.data, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (iocs) observe(iorw ? 1 : 0, int'(ioaddr), int'(databus));
         if (rx_valid) observe(2, 0, int'(rx_data));
         if (tx_ready) observe(3, 0, 0);
      end
   end

   task automatic drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      chk(name, exp_q.size(), 0);
   endtask

   task automatic reset_checks(input string name);
      chk({name, "_iocs"}, int'(iocs), 0);
      chk({name, "_iorw"}, int'(iorw), 1);
      chk({name, "_ioaddr"}, int'(ioaddr), 0);
      chk({name, "_tx_ready"}, int'(tx_ready), 0);
      chk({name, "_rx_valid"}, int'(rx_valid), 0);
      chk({name, "_rx_data"}, int'(rx_data), 0);
   endtask

   task automatic wait_txr(input string name);
      int found = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (tx_ready) begin
            tx_valid = 1'b0;
            found = 1;
            break;
         end
      end
      tx_valid = 1'b0;
      chk(name, found, 1);
   endtask

   // rda and tx_valid together: read wins; with echo the received byte goes out before the host byte.
   task automatic rd_and_tx(input logic [7:0] rd, input logic [7:0] tx, input string name);
      int c;
      @(posedge clk); #1;
      c = cyc;
      rd_val = rd; tx_data = tx; tbr = 1'b1; rda = 1'b1; tx_valid = 1'b1;
      push(1, 0, rd, c + 1);
      push(2, 0, rd, c + 2);
`ifdef SPART_ECHO_EN
      push(0, 0, rd, c + 4);
      push(0, 0, tx, c + 7);
      push(3, 0, 0, c + 7);
`else
      push(0, 0, tx, c + 4);
      push(3, 0, 0, c + 4);
`endif
      @(posedge clk); #1;
      rda = 1'b0;
      wait_txr({name, "_ack"});
      drain(name);
   endtask

   initial begin
      int c;
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      #12;
      reset_checks("reset0");
      // reset release with 9600 baud: divisor 324 = 0x0144
      @(posedge clk); #1;
      c = cyc;
      push(0, 2, 8'h44, c + 1);
      push(0, 3, 8'h01, c + 2);
      rst_n = 1'b1;
      drain("cfg_9600");

      // rate change to 38400: divisor 80 = 0x0050
      @(posedge clk); #1;
      c = cyc;
      br_cfg = 2'b11;
      push(0, 2, 8'h50, c + 1);
      push(0, 3, 8'h00, c + 2);
      drain("cfg_38400");

      // receive 0x5A with tbr low
      @(posedge clk); #1;
      c = cyc;
      rd_val = 8'h5A; rda = 1'b1;
      push(1, 0, 8'h5A, c + 1);
      push(2, 0, 8'h5A, c + 2);
      @(posedge clk); #1;
      rda = 1'b0;
      drain("rx_5a");

      // host write held off by tbr=0 for 10 cycles
      tx_data = 8'hA5; tx_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      c = cyc;
      tbr = 1'b1;
`ifdef SPART_ECHO_EN
      push(0, 0, 8'h5A, c + 1);
      push(0, 0, 8'hA5, c + 4);
      push(3, 0, 0, c + 4);
`else
      push(0, 0, 8'hA5, c + 1);
      push(3, 0, 0, c + 1);
`endif
      wait_txr("tx_a5_ack");
      drain("tx_a5");
      chk("rx_data_hold", int'(rx_data), 8'h5A);

      rd_and_tx(8'hC3, 8'h3C, "rd_vs_tx");
      rd_and_tx(8'h41, 8'h42, "echo_41_42");

      // rate change during a read lands at the following IDLE: 19200 -> 161 = 0x00A1
      tbr = 1'b0;
      @(posedge clk); #1;
      c = cyc;
      rd_val = 8'h77; rda = 1'b1;
      push(1, 0, 8'h77, c + 1);
      push(2, 0, 8'h77, c + 2);
      push(0, 2, 8'hA1, c + 4);
      push(0, 3, 8'h00, c + 5);
      @(posedge clk); #1;
      rda = 1'b0; br_cfg = 2'b10;
      drain("br_during_rd");

      // mid-operation reset with 4800 baud: divisor 650 = 0x028A; any echo is dropped
      @(posedge clk); #1;
      rst_n = 1'b0; br_cfg = 2'b00;
      #2;
      reset_checks("reset1");
      @(posedge clk); #1;
      c = cyc;
      push(0, 2, 8'h8A, c + 1);
      push(0, 3, 8'h02, c + 2);
      rst_n = 1'b1;
      drain("cfg_4800");
      tbr = 1'b1;
      repeat (8) @(posedge clk);
      drain("no_echo_after_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
